// File: rtl/formant_cos_solver.sv
// formant_cos_solver
//   Per-frame formant cosine solver. Collects FORMANTS cumulative T-value
//   triples, then for each formant forms interval differences, normalises
//   them, builds the two-product ratio with exact 2W-bit arithmetic and a
//   serial restoring divider, and streams one saturated Q1.(W-1) cosine.
//
// Ports
//   clk_in          single clock
//   rst_in          asynchronous active-low reset
//   start_in        frame start / abort pulse
//   t_valid_in      input beat valid
//   t_ready_out     input beat ready (registered)
//   t_data_in       cumulative T(0..2) at the right end of interval k
//   cos_valid_out   result valid, held until cos_ready_in
//   cos_ready_in    downstream ready
//   cos_data_out    Q1.(W-1) signed cosine
//   cos_index_out   0-based formant index of the result
//   cos_div0_out    denominator was zero for this result
//   frame_done_out  one-cycle pulse after the last result handshake
//   busy_out        solver is not idle
module formant_cos_solver #(
  parameter int BIT_WIDTH = 32,
  parameter int FORMANTS  = 5
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 start_in,
  input  logic                                 t_valid_in,
  output logic                                 t_ready_out,
  input  logic signed [BIT_WIDTH-1:0]          t_data_in [0:2],
  output logic                                 cos_valid_out,
  input  logic                                 cos_ready_in,
  output logic signed [BIT_WIDTH-1:0]          cos_data_out,
  output logic [$clog2(FORMANTS+1)-1:0]        cos_index_out,
  output logic                                 cos_div0_out,
  output logic                                 frame_done_out,
  output logic                                 busy_out
);

  localparam int W  = BIT_WIDTH;
  localparam int PW = 2 * W;
  localparam int KW = $clog2(FORMANTS + 1);
  localparam int SW = $clog2(W);
  localparam int DW = $clog2(W);
  localparam logic [W-1:0]  MAX_MAG = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] ONE_P   = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_COLLECT, S_DIFF, S_NORM, S_MUL, S_COMB,
    S_NUMP, S_DENP, S_PRE, S_DIV, S_FIN, S_OUT
  } state_t;

  state_t         state_reg, state_next;
  logic [KW-1:0]  k_reg;
  logic [KW-1:0]  k_prev;
  logic [2:0]     mul_cnt_reg;
  logic [DW-1:0]  div_cnt_reg;
  logic           beat_acc, out_hs, last_k;

  // Frame storage: no reset, overwritten every collection.
  logic [W-1:0]   t_mem [0:FORMANTS-1][0:2];

  logic [W-1:0]   r_reg   [0:2];
  logic [W-1:0]   diff_w  [0:2];
  logic [W-1:0]   shl_w   [0:2];
  logic [W-1:1]   lead_w  [0:2];
  logic [W-1:1]   lead_or;
  logic [SW-1:0]  norm_s;

  logic [W-1:0]   m_reg [0:4];
  logic [W-1:0]   anum_reg, bnum_reg, omb_reg, abd_reg;
  logic [W-1:0]   mul_a, mul_b;
  logic [PW-1:0]  mul_p;

  logic [PW-1:0]  num_reg, den_reg;
  logic [PW-1:0]  num_abs, den_abs;
  logic           sat_cmp;
  logic [PW:0]    rem_reg;
  logic [PW-1:0]  dsr_reg;
  logic           div_ge;
  logic [W-2:0]   q_reg;
  logic           sign_reg, div0_reg, sat_reg;
  logic [W-1:0]   q_mag, cos_res;

  assign last_k   = (k_reg == KW'(FORMANTS - 1));
  assign k_prev   = k_reg - KW'(1);
  assign busy_out = (state_reg != S_IDLE);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_next = state_reg;
    beat_acc   = 1'b0;
    out_hs     = 1'b0;
    if (start_in) begin
      // Start aborts anything in flight and wins over a coincident beat.
      state_next = S_COLLECT;
    end else begin
      case (state_reg)
        S_IDLE:    state_next = S_IDLE;
        S_COLLECT: begin
          if (t_valid_in && t_ready_out) begin
            beat_acc = 1'b1;
            if (last_k) state_next = S_DIFF;
          end
        end
        S_DIFF:    state_next = S_NORM;
        S_NORM:    state_next = S_MUL;
        S_MUL:     if (mul_cnt_reg == 3'd4) state_next = S_COMB;
        S_COMB:    state_next = S_NUMP;
        S_NUMP:    state_next = S_DENP;
        S_DENP:    state_next = S_PRE;
        S_PRE:     state_next = S_DIV;
        S_DIV:     if (div_cnt_reg == DW'(W - 2)) state_next = S_FIN;
        S_FIN:     state_next = S_OUT;
        S_OUT: begin
          if (cos_ready_in) begin
            out_hs     = 1'b1;
            state_next = last_k ? S_IDLE : S_DIFF;
          end
        end
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------ per-lane logic
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign diff_w[gi] = t_mem[k_reg][gi] - ((k_reg == '0) ? '0 : t_mem[k_prev][gi]);
      // A set bit j marks where bit j differs from bit j-1, i.e. the end of
      // the redundant sign run; the highest one bounds the safe left shift.
      assign lead_w[gi] = r_reg[gi][W-1:1] ^ r_reg[gi][W-2:0];
      assign shl_w[gi]  = r_reg[gi] << norm_s;
    end
  endgenerate

  assign lead_or = lead_w[0] | lead_w[1] | lead_w[2];

  always_comb begin
    norm_s = SW'(W - 2);
    for (int j = 1; j < W; j++) begin
      if (lead_or[j]) norm_s = SW'(W - 1 - j);
    end
  end

  // Shared multiplier: the five normalised cross products, then num, den.
  always_comb begin
    mul_a = r_reg[0];
    mul_b = r_reg[0];
    case (state_reg)
      S_MUL: begin
        case (mul_cnt_reg)
          3'd1:    begin mul_a = r_reg[1]; mul_b = r_reg[1]; end
          3'd2:    begin mul_a = r_reg[0]; mul_b = r_reg[1]; end
          3'd3:    begin mul_a = r_reg[1]; mul_b = r_reg[2]; end
          3'd4:    begin mul_a = r_reg[0]; mul_b = r_reg[2]; end
          default: begin mul_a = r_reg[0]; mul_b = r_reg[0]; end
        endcase
      end
      S_NUMP:  begin mul_a = anum_reg; mul_b = omb_reg; end
      S_DENP:  begin mul_a = bnum_reg; mul_b = abd_reg; end
      default: begin mul_a = r_reg[0]; mul_b = r_reg[0]; end
    endcase
  end

  // Low 2W bits of the product of sign-extended operands equal the exact
  // signed product.
  assign mul_p = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};

  assign num_abs = num_reg[PW-1] ? (~num_reg + ONE_P) : num_reg;
  assign den_abs = den_reg[PW-1] ? (~den_reg + ONE_P) : den_reg;
  // Ratio of 4 or more cannot be represented; a zero denominator lands here too.
  assign sat_cmp = ({2'b00, num_abs} >= {den_abs, 2'b00});

  // Divisor is 2|den| so the first quotient bit carries weight 2 of the ratio.
  assign div_ge  = (rem_reg >= {1'b0, dsr_reg});

  assign q_mag   = sat_reg ? MAX_MAG : {1'b0, q_reg};
  assign cos_res = sign_reg ? (~q_mag + ONE_W) : q_mag;

  // ------------------------------------------------------------ storage
  always_ff @(posedge clk_in) begin
    if (beat_acc) begin
      for (int i = 0; i < 3; i++) t_mem[k_reg][i] <= t_data_in[i];
    end
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= S_IDLE;
      k_reg          <= '0;
      mul_cnt_reg    <= '0;
      div_cnt_reg    <= '0;
      for (int i = 0; i < 3; i++) r_reg[i] <= '0;
      for (int i = 0; i < 5; i++) m_reg[i] <= '0;
      anum_reg       <= '0;
      bnum_reg       <= '0;
      omb_reg        <= '0;
      abd_reg        <= '0;
      num_reg        <= '0;
      den_reg        <= '0;
      rem_reg        <= '0;
      dsr_reg        <= '0;
      q_reg          <= '0;
      sign_reg       <= 1'b0;
      div0_reg       <= 1'b0;
      sat_reg        <= 1'b0;
      t_ready_out    <= 1'b0;
      cos_valid_out  <= 1'b0;
      cos_data_out   <= '0;
      cos_index_out  <= '0;
      cos_div0_out   <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      state_reg      <= state_next;
      t_ready_out    <= (state_next == S_COLLECT);
      cos_valid_out  <= (state_next == S_OUT);
      frame_done_out <= out_hs && last_k;
      if (start_in) begin
        k_reg <= '0;
      end else begin
        case (state_reg)
          S_COLLECT: if (beat_acc) k_reg <= last_k ? '0 : k_reg + KW'(1);
          S_DIFF: begin
            for (int i = 0; i < 3; i++) r_reg[i] <= diff_w[i];
          end
          S_NORM: begin
            for (int i = 0; i < 3; i++) r_reg[i] <= shl_w[i];
            mul_cnt_reg <= '0;
          end
          S_MUL: begin
            // Products shift in from the top: after five cycles
            // m_reg = {m00, m11, m01, m12, m02}.
            for (int i = 0; i < 4; i++) m_reg[i] <= m_reg[i+1];
            m_reg[4]    <= mul_p[PW-1:W];
            mul_cnt_reg <= mul_cnt_reg + 3'd1;
          end
          S_COMB: begin
            anum_reg <= m_reg[2] - m_reg[3];
            bnum_reg <= m_reg[1] - m_reg[4];
            omb_reg  <= m_reg[0] - m_reg[4];
            abd_reg  <= m_reg[0] - m_reg[1];
          end
          S_NUMP: num_reg <= mul_p;
          S_DENP: den_reg <= mul_p;
          S_PRE: begin
            sign_reg    <= num_reg[PW-1] ^ den_reg[PW-1];
            div0_reg    <= (den_reg == '0);
            sat_reg     <= sat_cmp;
            rem_reg     <= {1'b0, num_abs};
            dsr_reg     <= {den_abs[PW-2:0], 1'b0};
            q_reg       <= '0;
            div_cnt_reg <= '0;
          end
          S_DIV: begin
            rem_reg     <= (div_ge ? (rem_reg - {1'b0, dsr_reg}) : rem_reg) << 1;
            q_reg       <= {q_reg[W-3:0], div_ge};
            div_cnt_reg <= div_cnt_reg + DW'(1);
          end
          S_FIN: begin
            cos_data_out  <= cos_res;
            cos_index_out <= k_reg;
            cos_div0_out  <= div0_reg;
          end
          S_OUT: if (out_hs) k_reg <= last_k ? '0 : k_reg + KW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule
